// File: rtl/vga_timing_recovery_if.sv
// Sync-side VGA receiver bundle: sync inputs toward the receiver, recovered timing back out.
// The optional statistics counters exist only when VGA_RX_STATS_EN is defined.
interface vga_timing_recovery_if;
    logic       hSyncIn;
    logic       vSyncIn;
    logic       locked;
    logic       pixValid;
    logic [9:0] pixX;
    logic [8:0] pixY;
    logic       frameStart;
    logic [9:0] lineLen;
    logic [9:0] frameLines;
`ifdef VGA_RX_STATS_EN
    logic [7:0] lockLossCount;
    logic [7:0] badFrameCount;

    modport master (output hSyncIn, vSyncIn,
                    input  locked, pixValid, pixX, pixY, frameStart, lineLen, frameLines,
                           lockLossCount, badFrameCount);
    modport slave  (input  hSyncIn, vSyncIn,
                    output locked, pixValid, pixX, pixY, frameStart, lineLen, frameLines,
                           lockLossCount, badFrameCount);
`else
    modport master (output hSyncIn, vSyncIn,
                    input  locked, pixValid, pixX, pixY, frameStart, lineLen, frameLines);
    modport slave  (input  hSyncIn, vSyncIn,
                    output locked, pixValid, pixX, pixY, frameStart, lineLen, frameLines);
`endif
endinterface

// File: rtl/vga_timing_recovery.sv
// Recovers pixel coordinates, line length and frame height from active-low VGA syncs; VGA_RX_STATS_EN adds loss/bad-frame counters.
// Counters and flags update 1 clock after a sync edge, pix outputs are combinational from them; no backpressure.
module vga_timing_recovery #(
    parameter logic [9:0] HBP         = 10'd48,
    parameter logic [9:0] HACTIVE     = 10'd640,
    parameter logic [9:0] VBP         = 10'd32,
    parameter logic [9:0] VACTIVE     = 10'd480,
    parameter logic [3:0] TOL         = 4'd2,
    parameter logic [2:0] LOCK_FRAMES = 3'd2
) (
    input  logic                 vgaClk,
    input  logic                 rst,
    vga_timing_recovery_if.slave vga
);
    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    localparam logic [10:0] H_END = {1'b0, HBP} + {1'b0, HACTIVE};
    localparam logic [10:0] V_END = {1'b0, VBP} + {1'b0, VACTIVE};

    state_t      state;
    logic        h_prev, v_prev, h_rise, v_rise;
    logic [9:0]  h_cnt, v_cnt, line_len, frame_lines, ref_len, stored_lines;
    logic [2:0]  good_frames;
    logic        cap_pending, line_err, locked_q, frame_start;
    logic [10:0] new_len, len_diff;
    logic        h_sat, v_sat, len_bad, frame_good, pix_valid;

    assign h_rise     = ~h_prev & vga.hSyncIn;
    assign v_rise     = ~v_prev & vga.vSyncIn;
    assign h_sat      = &h_cnt;
    assign v_sat      = &v_cnt;
    assign new_len    = {1'b0, h_cnt} + 11'd1;
    assign len_diff   = (new_len > {1'b0, ref_len}) ? new_len - {1'b0, ref_len}
                                                    : {1'b0, ref_len} - new_len;
    assign len_bad    = len_diff > {7'd0, TOL};
    assign frame_good = ~line_err & ((good_frames == 3'd0) | (v_cnt == stored_lines));

    always_ff @(posedge vgaClk or posedge rst) begin
        if (rst) begin
            h_prev      <= 1'b1;
            v_prev      <= 1'b1;
            h_cnt       <= '0;
            v_cnt       <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            frame_start <= 1'b0;
            line_err    <= 1'b0;
        end else begin
            h_prev      <= vga.hSyncIn;
            v_prev      <= vga.vSyncIn;
            frame_start <= v_rise;
            if (h_rise) begin
                h_cnt    <= '0;
                line_len <= new_len[9:0];
            end else if (!h_sat) begin
                h_cnt <= h_cnt + 10'd1;
            end
            // vRise wins over a coincident hRise for the line count
            if (v_rise) begin
                v_cnt       <= '0;
                frame_lines <= v_cnt;
            end else if (h_rise && !v_sat) begin
                v_cnt <= v_cnt + 10'd1;
            end
            if (v_rise)
                line_err <= 1'b0;
            else if ((h_rise && !cap_pending && len_bad) || h_sat || v_sat)
                line_err <= 1'b1;
        end
    end

`ifdef VGA_RX_STATS_EN
    logic [7:0] lock_loss_count, bad_frame_count;
    assign vga.lockLossCount = lock_loss_count;
    assign vga.badFrameCount = bad_frame_count;
`endif

    always_ff @(posedge vgaClk or posedge rst) begin
        if (rst) begin
            state        <= SEARCH;
            good_frames  <= '0;
            ref_len      <= '0;
            stored_lines <= '0;
            cap_pending  <= 1'b1;
            locked_q     <= 1'b0;
`ifdef VGA_RX_STATS_EN
            lock_loss_count <= '0;
            bad_frame_count <= '0;
`endif
        end else begin
            case (state)
                SEARCH: begin
                    good_frames <= '0;
                    cap_pending <= 1'b1;
                    if (v_rise) state <= MEASURE;
                end
                MEASURE: begin
                    if (h_rise && cap_pending) begin
                        ref_len     <= new_len[9:0];
                        cap_pending <= 1'b0;
                    end
                    if (v_rise) begin
                        if (frame_good) begin
                            stored_lines <= v_cnt;
                            good_frames  <= good_frames + 3'd1;
                            if (good_frames + 3'd1 >= LOCK_FRAMES) begin
                                state    <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            // re-arm so the next frame measures a fresh reference line
                            good_frames <= '0;
                            cap_pending <= 1'b1;
`ifdef VGA_RX_STATS_EN
                            if (bad_frame_count != 8'hFF) bad_frame_count <= bad_frame_count + 8'd1;
`endif
                        end
                    end
                end
                LOCKED: begin
                    if (line_err || (v_rise && v_cnt != stored_lines)) begin
                        state       <= SEARCH;
                        locked_q    <= 1'b0;
                        good_frames <= '0;
`ifdef VGA_RX_STATS_EN
                        if (lock_loss_count != 8'hFF) lock_loss_count <= lock_loss_count + 8'd1;
`endif
                    end
                end
                default: begin
                    state    <= SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign pix_valid = locked_q
                     && (h_cnt >= HBP) && ({1'b0, h_cnt} < H_END)
                     && (v_cnt >= VBP) && ({1'b0, v_cnt} < V_END);

    assign vga.locked     = locked_q;
    assign vga.pixValid   = pix_valid;
    assign vga.pixX       = pix_valid ? h_cnt - HBP : '0;
    assign vga.pixY       = pix_valid ? v_cnt[8:0] - VBP[8:0] : '0;
    assign vga.frameStart = frame_start;
    assign vga.lineLen    = line_len;
    assign vga.frameLines = frame_lines;
endmodule
